// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: opcode encoding, datapath width defaults, stage state encoding.
package alu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand from the MEM/WB writeback candidates (MEM wins, r0 never forwarded).
// Purely combinational, no latency, no flow control.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]  reg_data,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  value
);

  logic addr_nz;
  logic mem_hit;
  logic wb_hit;

  assign addr_nz = |addr;
  assign mem_hit = mem_we && (mem_addr == addr) && addr_nz;
  assign wb_hit  = wb_we && (wb_addr == addr) && addr_nz;

  always_comb begin
    value = reg_data;
    if (mem_hit) begin
      value = mem_data;
    end else if (wb_hit) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry ALU operand register with operand forwarding (ALU_ISSUE_FWD_EN) between decode and EX.
// Latency 1 cycle; holds while out_ready=0, drain+fill in one cycle; flush overrides all.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_alu_src,
  input  logic [2:0]         in_alu_op,
  input  logic [RADDR_W-1:0] in_rs_addr,
  input  logic [RADDR_W-1:0] in_rt_addr,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic               in_reg_write,
  input  logic               fwd_mem_we,
  input  logic [RADDR_W-1:0] fwd_mem_addr,
  input  logic [DATA_W-1:0]  fwd_mem_data,
  input  logic               fwd_wb_we,
  input  logic [RADDR_W-1:0] fwd_wb_addr,
  input  logic [DATA_W-1:0]  fwd_wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  srcA,
  output logic [DATA_W-1:0]  srcB,
  output logic [2:0]         opcode,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_reg_write
);

`ifdef ALU_ISSUE_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  stage_state_t state;
  logic         mem_we_eff;
  logic         wb_we_eff;
  logic         take;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_fwd;

  // With forwarding disabled the muxes see no writeback and pass register data straight through.
  assign mem_we_eff = fwd_mem_we & FWD_EN;
  assign wb_we_eff  = fwd_wb_we & FWD_EN;

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_a (
    .addr     (in_rs_addr),
    .reg_data (in_rs_data),
    .mem_we   (mem_we_eff),
    .mem_addr (fwd_mem_addr),
    .mem_data (fwd_mem_data),
    .wb_we    (wb_we_eff),
    .wb_addr  (fwd_wb_addr),
    .wb_data  (fwd_wb_data),
    .value    (a_val)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_b (
    .addr     (in_rt_addr),
    .reg_data (in_rt_data),
    .mem_we   (mem_we_eff),
    .mem_addr (fwd_mem_addr),
    .mem_data (fwd_mem_data),
    .wb_we    (wb_we_eff),
    .wb_addr  (fwd_wb_addr),
    .wb_data  (fwd_wb_data),
    .value    (b_fwd)
  );

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign take      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_EMPTY;
      srcA          <= '0;
      srcB          <= '0;
      opcode        <= 3'b000;
      out_rd_addr   <= '0;
      out_reg_write <= 1'b0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (take) begin
      state         <= ST_FULL;
      srcA          <= a_val;
      srcB          <= in_alu_src ? in_imm : b_fwd;
      opcode        <= in_alu_op;
      out_rd_addr   <= in_rd_addr;
      out_reg_write <= in_reg_write;
    end else if (out_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_alu_src, in_reg_write;
  logic          in_ready;
  logic [DW-1:0] in_rs_data, in_rt_data, in_imm;
  logic [2:0]    in_alu_op;
  logic [AW-1:0] in_rs_addr, in_rt_addr, in_rd_addr;
  logic          fwd_mem_we, fwd_wb_we;
  logic [AW-1:0] fwd_mem_addr, fwd_wb_addr;
  logic [DW-1:0] fwd_mem_data, fwd_wb_data;
  logic          flush, out_valid, out_ready, out_reg_write;
  logic [DW-1:0] srcA, srcB;
  logic [2:0]    opcode;
  logic [AW-1:0] out_rd_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the one-entry stage as the spec describes it.
  logic          m_full;
  logic [DW-1:0] m_a, m_b;
  logic [2:0]    m_op;
  logic [AW-1:0] m_rd;
  logic          m_rw;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_rs_addr(in_rs_addr),
    .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .srcA(srcA),
    .srcB(srcB), .opcode(opcode), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  function automatic logic [DW-1:0] resolve(input logic [AW-1:0] addr, input logic [DW-1:0] rdata);
`ifdef ALU_ISSUE_FWD_EN
    if (addr != 0 && fwd_mem_we && fwd_mem_addr == addr) return fwd_mem_data;
    if (addr != 0 && fwd_wb_we && fwd_wb_addr == addr) return fwd_wb_data;
`endif
    return rdata;
  endfunction

  function automatic logic exp_ready();
    return !flush && (!m_full || out_ready);
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_alu_src = 0; in_reg_write = 0; in_alu_op = 3'b000;
    in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0;
    fwd_mem_we = 0; fwd_mem_addr = '0; fwd_mem_data = '0;
    fwd_wb_we = 0; fwd_wb_addr = '0; fwd_wb_data = '0;
    flush = 0; out_ready = 0;
  endtask

  task automatic model_reset();
    m_full = 0; m_a = '0; m_b = '0; m_op = 3'b000; m_rd = '0; m_rw = 0;
  endtask

  // Advance one clock: model next state is computed from the inputs held across the edge.
  task automatic step();
    logic take, nf;
    logic [DW-1:0] na, nb;
    take = in_valid && exp_ready();
    na = resolve(in_rs_addr, in_rs_data);
    nb = in_alu_src ? in_imm : resolve(in_rt_addr, in_rt_data);
    if (flush) nf = 0;
    else if (take) nf = 1;
    else if (out_ready) nf = 0;
    else nf = m_full;
    @(posedge clk);
    #1;
    if (!flush && take) begin
      m_a = na; m_b = nb; m_op = in_alu_op; m_rd = in_rd_addr; m_rw = in_reg_write;
    end
    m_full = nf;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++;
    if ({srcA, srcB, opcode, out_rd_addr, out_reg_write} !== '0)
      begin errors++; $display("FAIL reset_fields got %h/%h/%b/%0d/%b want zero", srcA, srcB, opcode, out_rd_addr, out_reg_write); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    in_valid = 1; in_rs_data = 32'h5; in_rt_data = 32'h3; in_alu_op = ALU_SUB;
    in_rs_addr = 5'd1; in_rt_addr = 5'd2; in_rd_addr = 5'd9; in_reg_write = 1; out_ready = 1;
    step();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || srcA !== 32'h5 || srcB !== 32'h3 || opcode !== 3'b110)
      begin errors++; $display("FAIL basic got v=%0b a=%h b=%h op=%b want 1/5/3/110", out_valid, srcA, srcB, opcode); end
    checks++;
    if (out_rd_addr !== 5'd9 || out_reg_write !== 1'b1)
      begin errors++; $display("FAIL basic_dest got %0d/%b want 9/1", out_rd_addr, out_reg_write); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_forward();
    logic [DW-1:0] want;
    in_valid = 1; out_ready = 1; in_rs_addr = 5'd8; in_rs_data = $urandom;
    fwd_mem_we = 1; fwd_mem_addr = 5'd8; fwd_mem_data = 32'hAA;
    fwd_wb_we = 1; fwd_wb_addr = 5'd8; fwd_wb_data = 32'hBB;
`ifdef ALU_ISSUE_FWD_EN
    want = 32'hAA;
`else
    want = in_rs_data;
`endif
    step();
    checks++;
    if (srcA !== want || srcA !== m_a) begin errors++; $display("FAIL fwd_mem_wins got %h want %h", srcA, want); end
    in_rs_addr = 5'd0; fwd_mem_addr = 5'd0; fwd_wb_addr = 5'd0; in_rs_data = $urandom;
    want = in_rs_data;
    step();
    checks++;
    if (srcA !== want) begin errors++; $display("FAIL fwd_r0 got %h want %h", srcA, want); end
    fwd_mem_we = 0; fwd_mem_addr = 5'd3; in_rs_addr = 5'd3; in_rs_data = $urandom;
    fwd_wb_addr = 5'd3; fwd_wb_data = $urandom;
    step();
    checks++;
    if (srcA !== m_a) begin errors++; $display("FAIL fwd_wb got %h want %h", srcA, m_a); end
    idle_inputs(); out_ready = 1;
    step();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ha, hb;
    in_valid = 1; out_ready = 1; in_rs_addr = 5'd4; in_rs_data = 32'h1111; in_rt_data = 32'h2222;
    in_alu_op = ALU_ADD; fwd_mem_we = 1; fwd_mem_addr = 5'd4; fwd_mem_data = 32'h3333;
    step();
    ha = m_a; hb = m_b;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      fwd_mem_data = $urandom; fwd_wb_data = $urandom; in_rs_data = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %0b want 0", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || srcA !== ha || srcB !== hb || opcode !== ALU_ADD)
        begin errors++; $display("FAIL bp_hold cyc%0d got v=%0b a=%h b=%h want 1/%h/%h", i, out_valid, srcA, srcB, ha, hb); end
    end
    out_ready = 1; in_valid = 1; in_rs_addr = 5'd6; in_rs_data = 32'hCAFE; in_alu_op = ALU_OR;
    step();
    checks++;
    if (out_valid !== 1'b1 || srcA !== 32'hCAFE || opcode !== ALU_OR)
      begin errors++; $display("FAIL bp_refill got v=%0b a=%h op=%b want 1/cafe/001", out_valid, srcA, opcode); end
    idle_inputs(); out_ready = 1;
    step();
  endtask

  task automatic test_imm();
    in_valid = 1; out_ready = 1; in_alu_src = 1; in_imm = 32'hFFFFFFFC;
    in_rt_addr = 5'd7; in_rt_data = 32'h1234;
    fwd_mem_we = 1; fwd_mem_addr = 5'd7; fwd_mem_data = 32'h5555;
    fwd_wb_we = 1; fwd_wb_addr = 5'd7; fwd_wb_data = 32'h6666;
    step();
    checks++;
    if (srcB !== 32'hFFFFFFFC) begin errors++; $display("FAIL imm got %h want fffffffc", srcB); end
    idle_inputs(); out_ready = 1;
    step();
  endtask

  task automatic test_flush();
    in_valid = 1; out_ready = 1; in_rs_data = 32'h77;
    step();
    out_ready = 0; flush = 1; in_rs_data = 32'h88;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
    step();
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %0b want 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    in_valid = 1; out_ready = 0; in_rs_data = 32'h99; in_rt_data = 32'h42; in_alu_op = ALU_SLT;
    in_rd_addr = 5'd3; in_reg_write = 1;
    step();
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || {srcA, srcB, opcode, out_rd_addr, out_reg_write} !== '0)
      begin errors++; $display("FAIL async_reset got v=%0b a=%h b=%h op=%b", out_valid, srcA, srcB, opcode); end
    #3;
    rst_n = 1; idle_inputs();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL async_release got rdy=%0b v=%0b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0); in_alu_src = $urandom_range(0, 1);
      in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom; in_alu_op = $urandom_range(0, 7);
      in_rs_addr = $urandom_range(0, 3); in_rt_addr = $urandom_range(0, 3);
      in_rd_addr = $urandom_range(0, 31); in_reg_write = $urandom_range(0, 1);
      fwd_mem_we = $urandom_range(0, 1); fwd_mem_addr = $urandom_range(0, 3); fwd_mem_data = $urandom;
      fwd_wb_we = $urandom_range(0, 1); fwd_wb_addr = $urandom_range(0, 3); fwd_wb_data = $urandom;
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_in_ready i=%0d got %0b want %0b", i, in_ready, exp_ready()); end
      step();
      checks++;
      if (out_valid !== m_full) begin errors++; $display("FAIL rand_valid i=%0d got %0b want %0b", i, out_valid, m_full); end
      else if (m_full && (srcA !== m_a || srcB !== m_b || opcode !== m_op || out_rd_addr !== m_rd || out_reg_write !== m_rw)) begin
        errors++;
        $display("FAIL rand_data i=%0d got %h/%h/%b/%0d/%b want %h/%h/%b/%0d/%b", i, srcA, srcB, opcode,
                 out_rd_addr, out_reg_write, m_a, m_b, m_op, m_rd, m_rw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_backpressure();
    test_imm();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
